// File: rtl/event_push_arbiter.sv
// Per-source pending-event counters feeding a round-robin arbiter that pushes
// one event ID per cycle into a downstream FIFO using a valid/grant handshake.
module event_push_arbiter #(
  parameter int unsigned NB_SRC       = 8,
  parameter int unsigned EVT_ID_WIDTH = 8,
  parameter int unsigned ID_BASE      = 0,
  parameter int unsigned CNT_WIDTH    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NB_SRC-1:0]       src_evt_i,
  input  logic [NB_SRC-1:0]       src_en_i,
  output logic                    evt_valid_o,
  output logic [EVT_ID_WIDTH-1:0] evt_data_o,
  input  logic                    evt_grant_i,
  input  logic [NB_SRC-1:0]       err_clr_i,
  output logic [NB_SRC-1:0]       err_o,
  output logic                    busy_o
);

  localparam int unsigned PtrW = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic {StIdle = 1'b0, StHold = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q [NB_SRC];
  logic [CNT_WIDTH-1:0]    cnt_d [NB_SRC];
  logic [PtrW-1:0]         rr_q, rr_d;
  logic [EVT_ID_WIDTH-1:0] data_q, data_d;
  logic [NB_SRC-1:0]       err_q, err_d;
  logic [NB_SRC-1:0]       req;
  logic                    win_found;
  logic [PtrW-1:0]         win_idx;
  logic                    load;
  logic                    any_cnt;

  always_comb begin
    any_cnt = 1'b0;
    for (int unsigned k = 0; k < NB_SRC; k++) begin
      req[k]  = src_en_i[k] && (cnt_q[k] != '0);
      any_cnt = any_cnt || (cnt_q[k] != '0);
    end
  end

  // First requesting source at or above rr_q, wrapping past NB_SRC-1.
  always_comb begin : p_search
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NB_SRC; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NB_SRC) idx = idx - NB_SRC;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PtrW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          load    = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (evt_grant_i) begin
          if (win_found) load = 1'b1;
          else           state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d = data_q;
    rr_d   = rr_q;
    if (load) begin
      data_d = EVT_ID_WIDTH'(ID_BASE + 32'(win_idx));
      rr_d   = (win_idx == PtrW'(NB_SRC - 1)) ? '0 : win_idx + PtrW'(1);
    end
  end

  // A coinciding increment and decrement cancel; saturation flags the error.
  always_comb begin : p_cnt
    logic inc, dec;
    inc   = 1'b0;
    dec   = 1'b0;
    err_d = err_q & ~err_clr_i;
    for (int unsigned k = 0; k < NB_SRC; k++) begin
      inc      = src_evt_i[k] && src_en_i[k];
      dec      = load && (win_idx == PtrW'(k));
      cnt_d[k] = cnt_q[k];
      if (!src_en_i[k]) begin
        cnt_d[k] = '0;
      end else if (inc && !dec) begin
        if (cnt_q[k] == CntMax) err_d[k] = 1'b1;
        else                    cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end else if (dec && !inc) begin
        cnt_d[k] = cnt_q[k] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rr_q    <= '0;
      data_q  <= '0;
      err_q   <= '0;
      for (int unsigned k = 0; k < NB_SRC; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      for (int unsigned k = 0; k < NB_SRC; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign evt_valid_o = (state_q == StHold);
  assign evt_data_o  = data_q;
  assign err_o       = err_q;
  assign busy_o      = evt_valid_o || any_cnt;

endmodule
